// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake and data bundle between the CPU sequencer and alu_seq.
//   in_valid/in_ready   : operation issue handshake (sequencer -> ALU)
//   op, ai, bi, ci, dec : operation code, operands, carry in, decimal request
//   out_valid/out_ready : result handshake (ALU -> consumer)
//   res, flag_c/v/n/z   : result and condition flags
// master = sequencer side, slave = ALU side.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic             ci;
    logic             dec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;
    logic             flag_z;

    modport master (
        output in_valid, op, ai, bi, ci, dec, out_ready,
        input  in_ready, out_valid, res, flag_c, flag_v, flag_n, flag_z
    );

    modport slave (
        input  in_valid, op, ai, bi, ci, dec, out_ready,
        output in_ready, out_valid, res, flag_c, flag_v, flag_n, flag_z
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU. Binary AND/OR/XOR/shift/ADD/SUB/PASS complete in one
// cycle; 6502-style decimal ADD/SUB iterate one nibble per cycle, LSB first.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset, aborts any operation in flight
//   bus  : alu_seq_if.slave (issue handshake, operands, result, flags)
// Parameters:
//   WIDTH   : operand width, multiple of 4 when DECIMAL=1
//   DECIMAL : 1 enables decimal ADD/SUB, 0 treats every op as binary
//
// state | meaning
// IDLE  | in_ready high, waiting for an op
// DEC   | decimal add/sub, one nibble processed per cycle
// DONE  | out_valid high, result/flags held until out_ready
module alu_seq #(
    parameter int WIDTH   = 8,
    parameter bit DECIMAL = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(NIB - 1);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SR   = 3'd3;
    localparam logic [2:0] OP_SL   = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic             is_sub;
    logic             v_hold;
    logic [CW-1:0]    cnt;

    // Binary result, computed straight from the bus so it can be registered
    // on the accept edge.
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] bin_res;
    logic             bin_c;
    logic             bin_v;
    logic             dec_op;

    always_comb begin
        s       = bus.ai | bus.bi;
        b_eff   = (bus.op == OP_SUB) ? ~bus.bi : bus.bi;
        sum     = {1'b0, bus.ai} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.ci};
        bin_res = bus.ai;
        bin_c   = 1'b0;
        bin_v   = 1'b0;
        case (bus.op)
            OP_AND: bin_res = bus.ai & bus.bi;
            OP_OR:  bin_res = bus.ai | bus.bi;
            OP_XOR: bin_res = bus.ai ^ bus.bi;
            OP_SR: begin
                bin_res = {bus.ci, s[WIDTH-1:1]};
                bin_c   = s[0];
            end
            OP_SL: begin
                bin_res = {s[WIDTH-2:0], bus.ci};
                bin_c   = s[WIDTH-1];
            end
            OP_ADD, OP_SUB: begin
                bin_res = sum[WIDTH-1:0];
                bin_c   = sum[WIDTH];
                bin_v   = (bus.ai[WIDTH-1] ^ sum[WIDTH-1]) & (b_eff[WIDTH-1] ^ sum[WIDTH-1]);
            end
            default: bin_res = bus.ai;
        endcase
        dec_op = DECIMAL && bus.dec && ((bus.op == OP_ADD) || (bus.op == OP_SUB));
    end

    // One decimal digit step on the low nibble of the operand shifters.
    // t_sub is 6 bits so a_k - b_k - borrow (down to -16) keeps a valid sign bit.
    logic [4:0]       t_add;
    logic [5:0]       t_sub;
    logic [3:0]       digit;
    logic             c_nxt;
    logic [WIDTH+3:0] acc_wide;
    logic [WIDTH-1:0] acc_nxt;

    always_comb begin
        t_add = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'd0, carry};
        t_sub = {2'b0, a_sh[3:0]} - {2'b0, b_sh[3:0]} - {5'd0, ~carry};
        if (is_sub) begin
            if (t_sub[5]) begin
                digit = t_sub[3:0] - 4'd6;
                c_nxt = 1'b0;
            end else begin
                digit = t_sub[3:0];
                c_nxt = 1'b1;
            end
        end else if (t_add > 5'd9) begin
            digit = t_add[3:0] + 4'd6;
            c_nxt = 1'b1;
        end else begin
            digit = t_add[3:0];
            c_nxt = 1'b0;
        end
        // New digit enters at the top; after WIDTH/4 steps digit 0 sits at the bottom.
        acc_wide = {digit, acc} >> 4;
        acc_nxt  = acc_wide[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.res       <= '0;
            bus.flag_c    <= 1'b0;
            bus.flag_v    <= 1'b0;
            bus.flag_n    <= 1'b0;
            bus.flag_z    <= 1'b0;
            a_sh          <= '0;
            b_sh          <= '0;
            acc           <= '0;
            carry         <= 1'b0;
            is_sub        <= 1'b0;
            v_hold        <= 1'b0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        bus.in_ready <= 1'b0;
                        if (dec_op) begin
                            state  <= DEC;
                            a_sh   <= bus.ai;
                            b_sh   <= bus.bi;
                            acc    <= '0;
                            carry  <= bus.ci;
                            is_sub <= (bus.op == OP_SUB);
                            v_hold <= bin_v;
                            cnt    <= CNT_LOAD;
                        end else begin
                            state         <= DONE;
                            bus.out_valid <= 1'b1;
                            bus.res       <= bin_res;
                            bus.flag_c    <= bin_c;
                            bus.flag_v    <= bin_v;
                            bus.flag_n    <= bin_res[WIDTH-1];
                            bus.flag_z    <= (bin_res == '0);
                        end
                    end
                end
                DEC: begin
                    carry <= c_nxt;
                    acc   <= acc_nxt;
                    a_sh  <= a_sh >> 4;
                    b_sh  <= b_sh >> 4;
                    if (cnt == '0) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                        bus.res       <= acc_nxt;
                        bus.flag_c    <= c_nxt;
                        bus.flag_v    <= v_hold;
                        bus.flag_n    <= acc_nxt[WIDTH-1];
                        bus.flag_z    <= (acc_nxt == '0);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W), .DECIMAL(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: signed/unsigned integer arithmetic and a per-digit BCD loop.
    function automatic void model(input int op, input int a, input int b, input int ci,
                                  input int dec, output int r, output int c,
                                  output int v, output int n, output int z);
        int s, sa, sb, sv, sum, cc, an, bn, t;
        r = 0; c = 0; v = 0;
        s  = a | b;
        sa = (a > 127) ? a - 256 : a;
        sb = (b > 127) ? b - 256 : b;
        case (op)
            0: r = a & b;
            1: r = a | b;
            2: r = a ^ b;
            3: begin r = (ci << 7) | (s >> 1); c = s & 1; end
            4: begin r = ((s << 1) | ci) & 255; c = (s >> 7) & 1; end
            5: begin
                sum = a + b + ci;
                r = sum & 255; c = (sum > 255) ? 1 : 0;
                sv = sa + sb + ci;
                v = (sv > 127 || sv < -128) ? 1 : 0;
            end
            6: begin
                sum = a + (255 - b) + ci;
                r = sum & 255; c = (sum > 255) ? 1 : 0;
                sv = sa - sb - (1 - ci);
                v = (sv > 127 || sv < -128) ? 1 : 0;
            end
            default: r = a;
        endcase
        if (dec != 0 && (op == 5 || op == 6)) begin
            cc = ci;
            r  = 0;
            for (int k = 0; k < W / 4; k++) begin
                an = (a >> (4 * k)) & 15;
                bn = (b >> (4 * k)) & 15;
                if (op == 5) begin
                    t = an + bn + cc;
                    if (t > 9) begin t = t + 6; cc = 1; end else cc = 0;
                end else begin
                    t = an - bn - (1 - cc);
                    if (t < 0) begin t = t - 6; cc = 0; end else cc = 1;
                end
                r = r | ((t & 15) << (4 * k));
            end
            c = cc;
        end
        n = (r >> 7) & 1;
        z = (r == 0) ? 1 : 0;
    endfunction

    // Issue one op, check latency/result/flags, optionally hold DONE with
    // out_ready low while offering a different op, then release.
    task automatic run_op(input string name, input int op, input int a, input int b,
                          input int ci, input int dec, input int hold);
        int r, c, v, n, z, lat, exp_lat;
        logic [31:0] rv;
        logic [W-1:0] res_q;
        model(op, a, b, ci, dec, r, c, v, n, z);
        rv = r;
        exp_lat = (dec != 0 && (op == 5 || op == 6)) ? W / 4 + 1 : 1;
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) @(posedge clk) #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_wait: in_ready=%b required 1", name, bus.in_ready);
        end
        bus.op = op[2:0]; bus.ai = a[W-1:0]; bus.bi = b[W-1:0];
        bus.ci = ci[0]; bus.dec = dec[0]; bus.in_valid = 1'b1;
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk) #1;
            lat++;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (bus.res !== rv[W-1:0] || bus.flag_c !== rv[31:0] * 0 + c[0] ||
            bus.flag_v !== v[0] || bus.flag_n !== n[0] || bus.flag_z !== z[0]) begin
            n_fail++;
            $display("FAIL %s result: res=%h c=%b v=%b n=%b z=%b required res=%h c=%0d v=%0d n=%0d z=%0d",
                     name, bus.res, bus.flag_c, bus.flag_v, bus.flag_n, bus.flag_z,
                     rv[W-1:0], c, v, n, z);
        end
        res_q = bus.res;
        if (hold > 0) begin
            bus.op = 3'd5; bus.ai = ~a[W-1:0]; bus.bi = 8'h11; bus.in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk) #1;
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res !== res_q ||
                    bus.flag_c !== c[0] || bus.flag_v !== v[0] ||
                    bus.flag_n !== n[0] || bus.flag_z !== z[0]) begin
                    n_fail++;
                    $display("FAIL %s hold%0d: ov=%b ir=%b res=%h required ov=1 ir=0 res=%h",
                             name, i, bus.out_valid, bus.in_ready, bus.res, res_q);
                end
            end
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk) #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s release: ov=%b ir=%b required ov=0 ir=1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.res !== 8'h00 ||
            bus.flag_c !== 1'b0 || bus.flag_v !== 1'b0 ||
            bus.flag_n !== 1'b0 || bus.flag_z !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ir=%b ov=%b res=%h cvnz=%b%b%b%b required 1 0 00 0000",
                     bus.in_ready, bus.out_valid, bus.res,
                     bus.flag_c, bus.flag_v, bus.flag_n, bus.flag_z);
        end
    endtask

    task automatic test_directed();
        run_op("add_bin_50_50", 5, 'h50, 'h50, 0, 0, 0);
        run_op("sub_bin_50_b0", 6, 'h50, 'hB0, 1, 0, 0);
        run_op("sr_81",         3, 'h81, 'h00, 1, 0, 0);
        run_op("sl_81",         4, 'h81, 'h00, 0, 0, 0);
        run_op("add_dec_58_46", 5, 'h58, 'h46, 1, 1, 0);
        run_op("sub_dec_12_21", 6, 'h12, 'h21, 1, 1, 0);
        run_op("sub_dec_00_00", 6, 'h00, 'h00, 1, 1, 0);
        run_op("add_dec_99_01", 5, 'h99, 'h01, 0, 1, 0);
        run_op("xor_dec_ignored", 2, 'h5A, 'hFF, 1, 1, 0);
        run_op("pass_ff",       7, 'hFF, 'h00, 1, 0, 0);
    endtask

    task automatic test_random();
        int op, a, b, ci, dec;
        for (int i = 0; i < 60; i++) begin
            op  = $urandom_range(0, 7);
            a   = $urandom_range(0, 255);
            b   = $urandom_range(0, 255);
            ci  = $urandom_range(0, 1);
            dec = $urandom_range(0, 1);
            run_op("random", op, a, b, ci, dec, 0);
        end
    endtask

    task automatic test_hold();
        run_op("hold_bin_add", 5, 'h7F, 'h01, 0, 0, 5);
        run_op("hold_dec_sub", 6, 'h12, 'h21, 1, 1, 5);
    endtask

    task automatic test_back_to_back();
        bus.op = 3'd0; bus.ai = 8'hF0; bus.bi = 8'h3C; bus.ci = 1'b0; bus.dec = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk) #1;
        bus.op = 3'd1; bus.ai = 8'h01; bus.bi = 8'h02;
        bus.out_ready = 1'b1;
        @(posedge clk) #1;
        bus.out_ready = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res !== 8'h30) begin
            n_fail++;
            $display("FAIL b2b_no_accept_on_release: ov=%b ir=%b res=%h required ov=0 ir=1 res=30",
                     bus.out_valid, bus.in_ready, bus.res);
        end
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.res !== 8'h03) begin
            n_fail++;
            $display("FAIL b2b_second_op: ov=%b res=%h required ov=1 res=03",
                     bus.out_valid, bus.res);
        end
        bus.out_ready = 1'b1;
        @(posedge clk) #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.op = 3'd5; bus.ai = 8'h58; bus.bi = 8'h46; bus.ci = 1'b1; bus.dec = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk) #1;
        bus.in_valid = 1'b0;
        @(posedge clk) #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_dec: ov=%b ir=%b required ov=0 ir=1",
                     bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk) #1;
            n_checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_mid_stale%0d: ov=%b ir=%b required ov=0 ir=1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
        run_op("after_reset", 5, 'h50, 'h50, 0, 0, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = 3'd0; bus.ai = '0; bus.bi = '0;
        bus.ci = 1'b0; bus.dec = 1'b0; bus.out_ready = 1'b0;
        rst = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk) #1;
        test_directed();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
